binary_keying_modulator: RTL and testbench

BINARY_KEYING_MODULATOR -- requirements
Module: binary_keying_modulator

---
 rtl/binary_keying_pkg.sv | 20 ++
 rtl/sine_rom.sv | 81 ++++++++
 rtl/binary_keying_modulator.sv | 67 ++++++
 tb/tb_binary_keying_modulator.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_keying_pkg.sv
// Shared encodings and widths for the binary keying modulator.
// The accumulator width sets the table depth: one full carrier cycle is 2**PHASE_W samples.
package binary_keying_pkg;

  localparam int PHASE_W  = 6;
  localparam int SAMPLE_W = 16;

  localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'd32768;

  // Adding this offset to the phase moves it half a turn, which inverts the sine.
  localparam logic [PHASE_W-1:0] HALF_TURN = 6'd32;

  typedef enum logic [1:0] {
    MOD_FSK  = 2'b00,
    MOD_ASK  = 2'b01,
    MOD_BPSK = 2'b10,
    MOD_RSVD = 2'b11
  } mod_e;

endpackage

// File: rtl/sine_rom.sv
// Combinational 64-entry sine table in offset binary: 32768 + round(32767*sin(2*pi*k/64)).
module sine_rom
  import binary_keying_pkg::*;
(
  input  logic [PHASE_W-1:0]  addr,
  output logic [SAMPLE_W-1:0] sample
);

  always_comb begin
    sample = MIDSCALE;
    case (addr)
      6'd0:  sample = 16'd32768;
      6'd1:  sample = 16'd35980;
      6'd2:  sample = 16'd39161;
      6'd3:  sample = 16'd42280;
      6'd4:  sample = 16'd45307;
      6'd5:  sample = 16'd48214;
      6'd6:  sample = 16'd50972;
      6'd7:  sample = 16'd53555;
      6'd8:  sample = 16'd55938;
      6'd9:  sample = 16'd58097;
      6'd10: sample = 16'd60013;
      6'd11: sample = 16'd61666;
      6'd12: sample = 16'd63041;
      6'd13: sample = 16'd64124;
      6'd14: sample = 16'd64905;
      6'd15: sample = 16'd65377;
      6'd16: sample = 16'd65535;
      6'd17: sample = 16'd65377;
      6'd18: sample = 16'd64905;
      6'd19: sample = 16'd64124;
      6'd20: sample = 16'd63041;
      6'd21: sample = 16'd61666;
      6'd22: sample = 16'd60013;
      6'd23: sample = 16'd58097;
      6'd24: sample = 16'd55938;
      6'd25: sample = 16'd53555;
      6'd26: sample = 16'd50972;
      6'd27: sample = 16'd48214;
      6'd28: sample = 16'd45307;
      6'd29: sample = 16'd42280;
      6'd30: sample = 16'd39161;
      6'd31: sample = 16'd35980;
      // Second half mirrors the first around midscale.
      6'd32: sample = 16'd32768;
      6'd33: sample = 16'd29556;
      6'd34: sample = 16'd26375;
      6'd35: sample = 16'd23256;
      6'd36: sample = 16'd20229;
      6'd37: sample = 16'd17322;
      6'd38: sample = 16'd14564;
      6'd39: sample = 16'd11981;
      6'd40: sample = 16'd9598;
      6'd41: sample = 16'd7439;
      6'd42: sample = 16'd5523;
      6'd43: sample = 16'd3870;
      6'd44: sample = 16'd2495;
      6'd45: sample = 16'd1412;
      6'd46: sample = 16'd631;
      6'd47: sample = 16'd159;
      6'd48: sample = 16'd1;
      6'd49: sample = 16'd159;
      6'd50: sample = 16'd631;
      6'd51: sample = 16'd1412;
      6'd52: sample = 16'd2495;
      6'd53: sample = 16'd3870;
      6'd54: sample = 16'd5523;
      6'd55: sample = 16'd7439;
      6'd56: sample = 16'd9598;
      6'd57: sample = 16'd11981;
      6'd58: sample = 16'd14564;
      6'd59: sample = 16'd17322;
      6'd60: sample = 16'd20229;
      6'd61: sample = 16'd23256;
      6'd62: sample = 16'd26375;
      6'd63: sample = 16'd29556;
      default: sample = MIDSCALE;
    endcase
  end

endmodule

// File: rtl/binary_keying_modulator.sv
// FSK/ASK/BPSK modulator: phase accumulator driving a sine table, one registered output sample per clock.
// Mode and frequency changes never touch the accumulator, so switching is phase-continuous.
module binary_keying_modulator
  import binary_keying_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  input  logic [1:0]          mod,
  input  logic [1:0]          freq,
  output logic [SAMPLE_W-1:0] out
);

  mod_e                mode;
  logic [PHASE_W-1:0]  phase_reg;
  logic [PHASE_W-1:0]  phase_next;
  logic [PHASE_W-1:0]  base_inc;
  logic [PHASE_W-1:0]  inc;
  logic [PHASE_W-1:0]  rom_addr;
  logic [SAMPLE_W-1:0] rom_sample;
  logic [SAMPLE_W-1:0] out_reg;
  logic [SAMPLE_W-1:0] out_next;

  assign mode     = mod_e'(mod);
  assign base_inc = PHASE_W'(freq) + PHASE_W'(1);

  sine_rom u_sine_rom (
    .addr   (rom_addr),
    .sample (rom_sample)
  );

  always_comb begin
    inc        = base_inc;
    rom_addr   = phase_reg;
    out_next   = rom_sample;

    // A mark in FSK doubles the carrier rate; the accumulator itself stays continuous.
    if (mode == MOD_FSK && din) begin
      inc = base_inc << 1;
    end

    if (mode == MOD_BPSK && din) begin
      rom_addr = phase_reg + HALF_TURN;
    end

    case (mode)
      MOD_ASK:  if (!din) out_next = MIDSCALE;
      MOD_RSVD: out_next = MIDSCALE;
      default:  out_next = rom_sample;
    endcase

    phase_next = phase_reg + inc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_reg <= '0;
      out_reg   <= MIDSCALE;
    end else begin
      phase_reg <= phase_next;
      out_reg   <= out_next;
    end
  end

  assign out = out_reg;

endmodule

// File: tb/tb_binary_keying_modulator.sv
// Scoreboard bench: every drive pushes the sample the DUT owes one edge later, each test pops and compares.
`timescale 1ns/1ps
module tb_binary_keying_modulator;
  import binary_keying_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic [1:0]  mod = 2'b00;
  logic [1:0]  freq = 2'b00;
  logic [15:0] out;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb_q[$];
  int          m_phase = 0;

  binary_keying_modulator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .mod   (mod),
    .freq  (freq),
    .out   (out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog out=%0d required=finish", out);
    $fatal(1, "watchdog expired");
  end

  function automatic int s_model(input int k);
    real x;
    x = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 64.0);
    return 32768 + $rtoi($floor(x + 0.5));
  endfunction

  // Drive one clock worth of inputs, queue the output expected after the edge, then step past it.
  task automatic drive(input logic r, input logic [1:0] m, input logic d, input logic [1:0] f);
    int exp_v;
    int step;
    rst_n = r;
    mod   = m;
    din   = d;
    freq  = f;
    if (!r) begin
      exp_v   = 32768;
      m_phase = 0;
    end else begin
      case (m)
        2'b00:   exp_v = s_model(m_phase);
        2'b01:   exp_v = d ? s_model(m_phase) : 32768;
        2'b10:   exp_v = d ? s_model((m_phase + 32) % 64) : s_model(m_phase);
        default: exp_v = 32768;
      endcase
      step = int'(f) + 1;
      if (m == 2'b00 && d) step = 2 * step;
      m_phase = (m_phase + step) % 64;
    end
    sb_q.push_back(16'(exp_v));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      exp_v = sb_q.pop_front();
      checks++;
      if (out !== exp_v || out !== 16'd32768) begin
        errors++;
        $display("FAIL reset_hold i=%0d out=%0d required=%0d", i, out, exp_v);
      end else $display("reset i=%0d out=%0d", i, out);
    end
  endtask

  task automatic test_ask();
    logic [15:0] exp_v;
    logic [15:0] spec_v;
    drive(1'b0, MOD_ASK, 1'b1, 2'b00);
    exp_v = sb_q.pop_front();
    checks++;
    if (out !== exp_v) begin
      errors++;
      $display("FAIL ask_reset out=%0d required=%0d", out, exp_v);
    end
    for (int e = 1; e <= 17; e++) begin
      drive(1'b1, MOD_ASK, 1'b1, 2'b00);
      exp_v = sb_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        errors++;
        $display("FAIL ask_sb edge=%0d out=%0d required=%0d", e, out, exp_v);
      end else $display("ask edge=%0d out=%0d", e, out);
      if (e == 1 || e == 2 || e == 9 || e == 17) begin
        spec_v = (e == 1) ? 16'd32768 : (e == 2) ? 16'd35980 : (e == 9) ? 16'd55938 : 16'd65535;
        checks++;
        if (out !== spec_v) begin
          errors++;
          $display("FAIL ask_point edge=%0d out=%0d required=%0d", e, out, spec_v);
        end
      end
    end
    for (int e = 0; e < 10; e++) begin
      drive(1'b1, MOD_ASK, 1'b0, 2'($urandom_range(0, 3)));
      exp_v = sb_q.pop_front();
      checks++;
      if (out !== exp_v || out !== 16'd32768) begin
        errors++;
        $display("FAIL ask_space e=%0d out=%0d required=%0d", e, out, exp_v);
      end else $display("ask space e=%0d out=%0d", e, out);
    end
  endtask

  task automatic test_bpsk();
    logic [15:0] exp_v;
    logic [15:0] spec_v;
    drive(1'b0, MOD_BPSK, 1'b1, 2'b00);
    void'(sb_q.pop_front());
    for (int e = 1; e <= 17; e++) begin
      drive(1'b1, MOD_BPSK, 1'b1, 2'b00);
      exp_v = sb_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        errors++;
        $display("FAIL bpsk_sb edge=%0d out=%0d required=%0d", e, out, exp_v);
      end else $display("bpsk edge=%0d out=%0d", e, out);
      if (e == 1 || e == 9 || e == 17) begin
        spec_v = (e == 1) ? 16'd32768 : (e == 9) ? 16'd9598 : 16'd1;
        checks++;
        if (out !== spec_v) begin
          errors++;
          $display("FAIL bpsk_point edge=%0d out=%0d required=%0d", e, out, spec_v);
        end
      end
    end
  endtask

  task automatic test_fsk();
    logic [15:0] exp_v;
    logic [1:0]  f_sel [3] = '{2'b00, 2'b00, 2'b11};
    logic        d_sel [3] = '{1'b0, 1'b1, 1'b1};
    int          at    [3] = '{17, 9, 9};
    logic [15:0] want  [3] = '{16'd65535, 16'd65535, 16'd32768};
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, MOD_FSK, d_sel[c], f_sel[c]);
      void'(sb_q.pop_front());
      for (int e = 1; e <= at[c]; e++) begin
        drive(1'b1, MOD_FSK, d_sel[c], f_sel[c]);
        exp_v = sb_q.pop_front();
        checks++;
        if (out !== exp_v) begin
          errors++;
          $display("FAIL fsk_sb case=%0d edge=%0d out=%0d required=%0d", c, e, out, exp_v);
        end else $display("fsk case=%0d edge=%0d out=%0d", c, e, out);
      end
      checks++;
      if (out !== want[c]) begin
        errors++;
        $display("FAIL fsk_point case=%0d out=%0d required=%0d", c, out, want[c]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [15:0] exp_v;
    logic [15:0] spec_v;
    drive(1'b0, MOD_BPSK, 1'b0, 2'b10);
    void'(sb_q.pop_front());
    for (int e = 0; e < 20; e++) begin
      drive(1'b1, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      exp_v = sb_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        errors++;
        $display("FAIL run_sb e=%0d out=%0d required=%0d", e, out, exp_v);
      end else $display("run e=%0d out=%0d", e, out);
    end
    drive(1'b0, MOD_FSK, 1'b1, 2'b11);
    exp_v = sb_q.pop_front();
    checks++;
    if (out !== exp_v || out !== 16'd32768) begin
      errors++;
      $display("FAIL midreset out=%0d required=%0d", out, exp_v);
    end else $display("midreset out=%0d", out);
    for (int e = 1; e <= 17; e++) begin
      drive(1'b1, MOD_ASK, 1'b1, 2'b00);
      exp_v = sb_q.pop_front();
      spec_v = (e == 2) ? 16'd35980 : (e == 9) ? 16'd55938 : (e == 17) ? 16'd65535 : exp_v;
      checks++;
      if (out !== exp_v || out !== spec_v) begin
        errors++;
        $display("FAIL post_reset edge=%0d out=%0d required=%0d", e, out, spec_v);
      end else $display("post reset edge=%0d out=%0d", e, out);
    end
  endtask

  task automatic test_mode_switch();
    logic [15:0] exp_v;
    drive(1'b0, MOD_FSK, 1'b0, 2'b00);
    void'(sb_q.pop_front());
    for (int e = 1; e <= 5; e++) begin
      drive(1'b1, MOD_FSK, 1'b0, 2'b00);
      void'(sb_q.pop_front());
    end
    drive(1'b1, MOD_BPSK, 1'b1, 2'b00);
    exp_v = sb_q.pop_front();
    checks++;
    if (out !== exp_v || out !== 16'd17322) begin
      errors++;
      $display("FAIL switch_bpsk out=%0d required=%0d", out, 16'd17322);
    end else $display("switch fsk->bpsk out=%0d", out);
    // Phase is now 6; back in FSK space the next sample must be S(6).
    drive(1'b1, MOD_FSK, 1'b0, 2'b00);
    exp_v = sb_q.pop_front();
    checks++;
    if (out !== exp_v || out !== 16'd50972) begin
      errors++;
      $display("FAIL switch_fsk out=%0d required=%0d", out, 16'd50972);
    end else $display("switch bpsk->fsk out=%0d", out);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_v;
    logic        r;
    for (int e = 0; e < 400; e++) begin
      r = ($urandom_range(0, 39) != 0);
      drive(r, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      exp_v = sb_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        errors++;
        $display("FAIL b2b e=%0d rst_n=%0b mod=%0d din=%0b freq=%0d out=%0d required=%0d",
                 e, rst_n, mod, din, freq, out, exp_v);
      end else $display("b2b e=%0d mod=%0d din=%0b out=%0d", e, mod, din, out);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_ask();
    test_bpsk();
    test_fsk();
    test_midstream_reset();
    test_mode_switch();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
